// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and limits for generic_bus_arbiter
package bus_arb_pkg;
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;
  typedef enum logic {IDLE, ACCESS} arb_state_t;
  localparam int ARB_MAX_PORTS = 8;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set bit of req & ~excl at or after start, wrapping modulo N
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [N-1:0] cand;
  int j;
  always_comb begin
    cand = req & ~excl;
    idx = '0;
    valid = 1'b0;
    j = 0;
    // walk the wrap order backwards so the nearest candidate is written last
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      j = (j >= N) ? j - N : j;
      if (cand[j]) begin
        idx = IW'(j);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/generic_bus_arbiter.sv
// generic_bus_arbiter: merges NUM_PORTS generic-bus requesters onto one downstream bus
module generic_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int        NUM_PORTS  = 2,
  parameter int        ADDR_WIDTH = 32,
  parameter int        DATA_WIDTH = 32,
  parameter arb_mode_t ARB_MODE   = ARB_RR,
  parameter int        MAX_STREAK = 4,
  localparam int       IW         = $clog2(NUM_PORTS),
  localparam int       BW         = DATA_WIDTH / 8
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] up_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] up_wdata,
  input  logic [NUM_PORTS-1:0][BW-1:0]         up_byte_en,
  input  logic [NUM_PORTS-1:0]                 up_ren,
  input  logic [NUM_PORTS-1:0]                 up_wen,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] up_rdata,
  output logic [NUM_PORTS-1:0]                 up_busy,
  output logic [ADDR_WIDTH-1:0]                out_addr,
  output logic [DATA_WIDTH-1:0]                out_wdata,
  output logic [BW-1:0]                        out_byte_en,
  output logic                                 out_ren,
  output logic                                 out_wen,
  input  logic [DATA_WIDTH-1:0]                out_rdata,
  input  logic                                 out_busy,
  output logic [IW-1:0]                        grant_idx
);
  localparam logic [NUM_PORTS-1:0] ONE = 1;
  arb_state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, last_q, last_d, pick_idx;
  logic [3:0] streak_cnt_q, streak_cnt_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
  logic [BW-1:0] hold_be_q, hold_be_d;
  logic [NUM_PORTS-1:0] req, excl, oth_last, oth_grant;
  logic in_access, done, abort, pick_valid;
  assign req       = up_ren | up_wen;
  assign in_access = state_q == ACCESS;
  assign done      = in_access && !out_busy;
  assign abort     = in_access && out_busy && !req[grant_q];
  assign oth_last  = req & ~(ONE << last_q);
  assign oth_grant = req & ~(ONE << grant_q);
  // a port that has hit its streak limit sits out one arbitration if anyone else is waiting
  assign excl = (ARB_MODE == ARB_FIXED && int'(streak_cnt_q) >= MAX_STREAK && |oth_last) ? ONE << last_q : '0;
  rr_priority_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
    .req   (req),
    .start (ARB_MODE == ARB_RR ? rr_ptr_q : '0),
    .excl  (excl),
    .idx   (pick_idx),
    .valid (pick_valid)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    last_d = last_q;
    streak_cnt_d = streak_cnt_q;
    if (!in_access) begin
      state_d = pick_valid ? ACCESS : IDLE;
      grant_d = pick_valid ? pick_idx : grant_q;
      streak_cnt_d = (pick_valid && |excl) ? 4'd0 : streak_cnt_q;
    end else if (done) begin
      state_d = IDLE;
      rr_ptr_d = (ARB_MODE != ARB_RR) ? rr_ptr_q : (grant_q == IW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
      last_d = grant_q;
      streak_cnt_d = !(|oth_grant) ? 4'd0 : (grant_q != last_q) ? 4'd1 : (streak_cnt_q == 4'd15) ? streak_cnt_q : streak_cnt_q + 4'd1;
    end else if (abort) begin
      state_d = IDLE;
    end
  end
  // downstream address/data keep the last granted values while idle
  always_comb begin
    hold_addr_d  = in_access ? up_addr[grant_q] : hold_addr_q;
    hold_wdata_d = in_access ? up_wdata[grant_q] : hold_wdata_q;
    hold_be_d    = in_access ? up_byte_en[grant_q] : hold_be_q;
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      last_q       <= '0;
      streak_cnt_q <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_be_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      last_q       <= last_d;
      streak_cnt_q <= streak_cnt_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_be_q    <= hold_be_d;
    end
  end
  always_comb begin
    up_busy = '1;
    up_rdata = '0;
    if (in_access) begin
      up_busy[grant_q] = out_busy;
      up_rdata[grant_q] = out_rdata;
    end
  end
  assign out_addr    = in_access ? up_addr[grant_q] : hold_addr_q;
  assign out_wdata   = in_access ? up_wdata[grant_q] : hold_wdata_q;
  assign out_byte_en = in_access ? up_byte_en[grant_q] : hold_be_q;
  assign out_ren     = in_access && up_ren[grant_q];
  assign out_wen     = in_access && up_wen[grant_q];
  assign grant_idx   = grant_q;
endmodule
